// File: rtl/audio_level_meter.sv
// Windowed audio level meter: per-window peak magnitude, LED thermometer bar with clip flag,
// and a peak-hold display value that decays once the hold period expires.
module audio_level_meter #(
  parameter int unsigned WINDOW       = 2048,
  parameter int unsigned HOLD_WINDOWS = 24,
  parameter int unsigned DECAY_SHIFT  = 3,
  parameter logic [15:0] CLIP_THRESH  = 16'd32000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_mic_valid_i,
  input  logic [15:0] data_mic_i,
  output logic [15:0] level_o,
  output logic        level_valid_o,
  output logic [15:0] peak_o,
  output logic [15:0] bar_o
);

  localparam int unsigned CNT_W  = $clog2(WINDOW);
  localparam int unsigned HOLD_W = $clog2(HOLD_WINDOWS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DECAY
  } state_e;

  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       run_max_q;
  logic              run_clip_q;
  logic [15:0]       level_q;
  logic [15:0]       bar_q;
  logic              level_valid_q;

  state_e            state_q, state_d;
  logic [15:0]       peak_q, peak_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [15:0] mag;
  logic        last_sample;
  logic [15:0] win_max;
  logic        win_clip;
  logic [14:0] therm;

  // -32768 has no positive twin in 16 bits, so it saturates to full scale.
  always_comb begin
    mag = data_mic_i;
    if (data_mic_i[15]) begin
      if (data_mic_i == 16'h8000) begin
        mag = 16'd32767;
      end else begin
        mag = 16'(~data_mic_i + 16'd1);
      end
    end
  end

  assign last_sample = (cnt_q == CNT_W'(WINDOW - 1));
  assign win_max     = (mag > run_max_q) ? mag : run_max_q;
  assign win_clip    = run_clip_q | (mag >= CLIP_THRESH);

  // Bit gi lights when the level reaches 2**gi.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_therm
      assign therm[gi] = |win_max[15:gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      run_max_q     <= '0;
      run_clip_q    <= 1'b0;
      level_q       <= '0;
      bar_q         <= '0;
      level_valid_q <= 1'b0;
    end else begin
      level_valid_q <= 1'b0;
      if (data_mic_valid_i) begin
        if (last_sample) begin
          cnt_q         <= '0;
          run_max_q     <= '0;
          run_clip_q    <= 1'b0;
          level_q       <= win_max;
          bar_q         <= {win_clip, therm};
          level_valid_q <= 1'b1;
        end else begin
          cnt_q      <= cnt_q + CNT_W'(1);
          run_max_q  <= win_max;
          run_clip_q <= win_clip;
        end
      end
    end
  end

  logic [15:0] step;
  logic [15:0] decayed;
  logic [15:0] decay_val;

  always_comb begin
    step = peak_q >> DECAY_SHIFT;
    if (step == 16'd0) begin
      step = 16'd1;
    end
  end

  assign decayed   = (peak_q > step) ? (peak_q - step) : 16'd0;
  assign decay_val = (level_q > decayed) ? level_q : decayed;

  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    if (level_valid_q) begin
      if ((level_q >= peak_q) && (level_q != 16'd0)) begin
        peak_d     = level_q;
        hold_cnt_d = HOLD_W'(HOLD_WINDOWS);
        state_d    = ST_HOLD;
      end else if (level_q < peak_q) begin
        case (state_q)
          ST_HOLD: begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            if (hold_cnt_q == HOLD_W'(1)) begin
              state_d = ST_DECAY;
            end
          end
          ST_DECAY: begin
            peak_d = decay_val;
            if (decay_val == 16'd0) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      peak_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign level_o       = level_q;
  assign level_valid_o = level_valid_q;
  assign peak_o        = peak_q;
  assign bar_o         = bar_q;

endmodule
